// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Function : Sequential double-dabble binary-to-BCD converter, one shift/add-3
//            step per clock. Optional leading-zero blanking: BIN2BCD_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter int IN_W   = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int              BCD_W      = 4 * DIGITS;
  localparam int              CNT_W      = $clog2(IN_W);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [BCD_W-1:0]   bcd_work;
  logic [IN_W-1:0]    bin_work;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;

  // All digits are corrected in parallel before the shift; max result is 12.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
      assign bcd_adj[4*i +: 4] = (bcd_work[4*i +: 4] >= 4'd5) ?
                                 (bcd_work[4*i +: 4] + 4'd3) : bcd_work[4*i +: 4];
    end
  endgenerate

  assign bcd_next = {bcd_adj[BCD_W-2:0], bin_work[IN_W-1]};

  // Reset holds the block unavailable even though state already reads IDLE.
  assign in_ready = rst_n && (state == IDLE);

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
      if (i == 0) begin : g_ones
        assign blank_next[i] = 1'b0;
      end else begin : g_upper
        assign blank_next[i] = ~|bcd_next[BCD_W-1:4*i];
      end
    end
  endgenerate
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      bcd_work  <= '0;
      bin_work  <= '0;
      bcd_out   <= '0;
      out_valid <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            bin_work <= bin_in;
            bcd_work <= '0;
            count    <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= bcd_next;
          bin_work <= {bin_work[IN_W-2:0], 1'b0};
          count    <= count + 1'b1;
          if (count == LAST_SHIFT) begin
            bcd_out   <= bcd_next;
`ifdef BIN2BCD_BLANK_EN
            blank     <= blank_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module   : tb_bin2bcd_seq
// Function : Self-checking bench for bin2bcd_seq (table vectors plus
//            handshake, back-to-back, reset-abort and ignore sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] bin_in;
  logic        out_valid;
  logic [27:0] bcd_out;
  logic [6:0]  blank;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.IN_W(20), .DIGITS(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bin;
    logic [27:0] bcd;
    logic [6:0]  blk;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_blank(input logic [6:0] b);
`ifdef BIN2BCD_BLANK_EN
    return b;
`else
    return 7'b0 & b;
`endif
  endfunction

  // Counts edges (sampled #1 after) until out_valid; -1 if the budget expires.
  task automatic wait_valid(output int n, output bit busy_ok);
    n = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      if (out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic convert(input vec_t v);
    int n;
    bit busy_ok;
    @(negedge clk);
    check("ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bin_in   = v.bin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = 20'hABCDE;
    check("ready_after_accept", 32'(in_ready), 32'd0);
    wait_valid(n, busy_ok);
    check("latency", 32'(n), 32'd20);
    check("ready_busy", 32'(busy_ok), 32'd1);
    check("bcd", 32'(bcd_out), 32'(v.bcd));
    check("blank", 32'(blank), 32'(exp_blank(v.blk)));
    @(posedge clk); #1;
    check("valid_pulse_end", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [9];
    vec_t v7;
    int   n;
    bit   busy_ok;
    bit   stable;
    bit   no_pulse;

    tbl[0] = '{20'd2,       28'h0000002, 7'b1111110};
    tbl[1] = '{20'd32,      28'h0000032, 7'b1111100};
    tbl[2] = '{20'd0,       28'h0000000, 7'b1111110};
    tbl[3] = '{20'hFFFFF,   28'h1048575, 7'b0000000};
    tbl[4] = '{20'd10,      28'h0000010, 7'b1111100};
    tbl[5] = '{20'd9,       28'h0000009, 7'b1111110};
    tbl[6] = '{20'd100000,  28'h0100000, 7'b1000000};
    tbl[7] = '{20'd65535,   28'h0065535, 7'b1100000};
    tbl[8] = '{20'd999999,  28'h0999999, 7'b1000000};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    bin_in   = '0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) convert(tbl[i]);

    // Back-to-back with bin_in changed during SHIFT.
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 20'd123456;
    @(posedge clk); #1;
    bin_in = 20'd999999;
    wait_valid(n, busy_ok);
    check("b2b_lat1", 32'(n), 32'd20);
    check("b2b_bcd1", 32'(bcd_out), 32'h0123456);
    n = -1;
    stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        n = i;
        break;
      end
      if (bcd_out !== 28'h0123456) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_gap", 32'(n), 32'd22);
    check("b2b_stable", 32'(stable), 32'd1);
    check("b2b_bcd2", 32'(bcd_out), 32'h0999999);
    @(posedge clk); #1;
    check("b2b_idle", 32'(in_ready), 32'd1);

    // Reset mid-conversion.
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 20'd54321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_blank", 32'(blank), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    no_pulse = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || bcd_out !== 28'h0) no_pulse = 1'b0;
    end
    check("abort_no_pulse", 32'(no_pulse), 32'd1);
    v7 = '{20'd7, 28'h0000007, 7'b1111110};
    convert(v7);

    // in_valid during SHIFT and DONE with another value is ignored.
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 20'd300;
    @(posedge clk); #1;
    bin_in = 20'd555;
    wait_valid(n, busy_ok);
    check("ign_lat", 32'(n), 32'd20);
    check("ign_busy", 32'(busy_ok), 32'd1);
    check("ign_bcd", 32'(bcd_out), 32'h0000300);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ign_idle", 32'(in_ready), 32'd1);
    no_pulse = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || bcd_out !== 28'h0000300) no_pulse = 1'b0;
    end
    check("ign_no_extra", 32'(no_pulse), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
